// File: rtl/io_responder_if.sv
// CPU port bus plus TX stream for io_responder; the CPU/bench side uses master,
// the responder uses slave.
interface io_responder_if;
  logic [15:0] base;
  logic [15:0] data;
  logic        flag;
  logic [15:0] in_data;
  logic [15:0] out_reg;
  logic [15:0] sw_in;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // TX handshake: a word transfers on every rising edge where tx_valid and
  // tx_ready are both high; tx_valid never depends on tx_ready.
  modport master (
    output base, data, flag, sw_in, tx_ready,
    input  in_data, out_reg, tx_data, tx_valid
  );

  modport slave (
    input  base, data, flag, sw_in, tx_ready,
    output in_data, out_reg, tx_data, tx_valid
  );
endinterface

// File: rtl/io_responder.sv
// Memory-mapped IO responder: output register, TX FIFO with overflow sticky,
// synchronised switch input and a registered read-back mux.
module io_responder #(
  parameter int FIFO_DEPTH = 8
) (
  input logic     clk,
  input logic     reset,
  io_responder_if.slave bus
);
  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [4:0]     DEPTH_C  = 5'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [15:0] ADDR_OUT  = 16'h0000;
  localparam logic [15:0] ADDR_PUSH = 16'h0001;
  localparam logic [15:0] ADDR_SEL  = 16'h0002;
  localparam logic [15:0] ADDR_CLR  = 16'h0003;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [4:0]       count;
  logic [4:0]       count_next;
  logic             overflow;
  logic [1:0]       rd_sel;
  logic [15:0]      wr_count;
  logic [15:0]      out_q;
  logic [15:0]      sync1;
  logic [15:0]      sync2;
  logic [15:0]      in_q;
  logic [15:0]      in_mux;
  logic [15:0]      status;

  logic wr_out;
  logic wr_push;
  logic wr_sel;
  logic wr_clr;
  logic wr_any;
  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic ovf_set;

  assign wr_out  = bus.flag && (bus.base == ADDR_OUT);
  assign wr_push = bus.flag && (bus.base == ADDR_PUSH);
  assign wr_sel  = bus.flag && (bus.base == ADDR_SEL);
  assign wr_clr  = bus.flag && (bus.base == ADDR_CLR);
  assign wr_any  = bus.flag && (bus.base[15:2] == 14'd0);

  assign full    = (count == DEPTH_C);
  assign empty   = (count == 5'd0);
  assign pop     = !empty && bus.tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = wr_push && (!full || pop);
  assign ovf_set = wr_push && full && !pop;

  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + 5'd1;
    end else if (!push_ok && pop) begin
      count_next = count - 5'd1;
    end
  end

  assign status = {8'h00, overflow, empty, full, count};

  always_comb begin
    in_mux = sync2;
    case (rd_sel)
      2'd0:    in_mux = sync2;
      2'd1:    in_mux = status;
      2'd2:    in_mux = out_q;
      default: in_mux = wr_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      rd_sel   <= 2'd0;
      wr_count <= 16'h0000;
      out_q    <= 16'h0000;
      sync1    <= 16'h0000;
      sync2    <= 16'h0000;
      in_q     <= 16'h0000;
    end else begin
      count <= count_next;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      // Clear wins over set if both were ever requested together.
      if (wr_clr) begin
        overflow <= 1'b0;
      end else if (ovf_set) begin
        overflow <= 1'b1;
      end
      if (wr_out) out_q  <= bus.data;
      if (wr_sel) rd_sel <= bus.data[1:0];
      if (wr_any) wr_count <= wr_count + 16'd1;
      sync1 <= bus.sw_in;
      sync2 <= sync1;
      in_q  <= in_mux;
    end
  end

  // Storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= bus.data;
    end
  end

  assign bus.tx_data  = mem[rd_ptr];
  assign bus.tx_valid = !empty;
  assign bus.in_data  = in_q;
  assign bus.out_reg  = out_q;
endmodule
